// File: rtl/fft_ctrl_pkg.sv
// Shared types and sizing helpers for the FFT stage scheduler and its address generator.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of the per-stage butterfly counter, which runs 0..N/2-1.
    function automatic int half_cnt_width(input int n_log2);
        return (n_log2 > 1) ? n_log2 - 1 : 1;
    endfunction

    function automatic int stage_width(input int n_log2);
        return $clog2(n_log2) + 1;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT butterfly address and twiddle generator for one (stage, k) pair.
module fft_addr_gen
    import fft_ctrl_pkg::*;
#(
    parameter int N_LOG2 = 4
) (
    input  logic [stage_width(N_LOG2)-1:0]    stage,
    input  logic [half_cnt_width(N_LOG2)-1:0] k,
    output logic [N_LOG2-1:0]                 addr_a,
    output logic [N_LOG2-1:0]                 addr_b,
    output logic [N_LOG2-2:0]                 tw_idx
);

    typedef logic [N_LOG2-1:0] addr_t;
    typedef logic [N_LOG2-2:0] tw_t;

    addr_t k_ext;
    addr_t span;
    addr_t pos;
    addr_t grp_sh;

    // addr_a is k with a zero bit inserted at position `stage`.
    always_comb begin
        k_ext  = addr_t'(k);
        span   = addr_t'(1) << stage;
        pos    = k_ext & (span - addr_t'(1));
        grp_sh = (k_ext >> stage) << (int'(stage) + 1);
        addr_a = grp_sh | pos;
        addr_b = addr_a + span;
        tw_idx = tw_t'(pos << (N_LOG2 - 1 - int'(stage)));
    end

endmodule

// File: rtl/fft_stage_scheduler.sv
// Issues one butterfly per cycle for an in-place radix-2 DIT FFT, draining between stages.
//  state | meaning
//  IDLE  | waiting for i_start
//  ISSUE | one butterfly read per cycle, k = 0..N/2-1
//  DRAIN | PIPE_LAT cycles letting the stage's writes land
//  DONE  | one-cycle o_done pulse, then back to IDLE
module fft_stage_scheduler
    import fft_ctrl_pkg::*;
#(
    parameter int N_LOG2   = 4,
    parameter int PIPE_LAT = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rd_en,
    output logic [N_LOG2-1:0]     o_rd_addr_a,
    output logic [N_LOG2-1:0]     o_rd_addr_b,
    output logic [N_LOG2-2:0]     o_tw_idx,
    output logic [$clog2(N_LOG2):0] o_stage,
    output logic                  o_wr_en,
    output logic [N_LOG2-1:0]     o_wr_addr_a,
    output logic [N_LOG2-1:0]     o_wr_addr_b
);

    localparam int KW = half_cnt_width(N_LOG2);
    localparam int SW = stage_width(N_LOG2);
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef logic [N_LOG2-1:0] addr_t;
    typedef logic [N_LOG2-2:0] tw_t;

    localparam logic [KW-1:0] K_LAST = KW'((1 << (N_LOG2 - 1)) - 1);
    localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);
    localparam logic [DW-1:0] D_LOAD = DW'(PIPE_LAT - 1);

    state_t        state;
    logic [KW-1:0] k_q;
    logic [DW-1:0] drain_cnt;

    logic [SW-1:0] gen_stage;
    logic [KW-1:0] gen_k;
    addr_t         gen_a;
    addr_t         gen_b;
    tw_t           gen_tw;
    logic          issue_nxt;

    // Address generator looks one issue ahead so the read outputs can be registered.
    always_comb begin
        gen_stage = o_stage;
        gen_k     = k_q + KW'(1);
        issue_nxt = 1'b0;
        case (state)
            IDLE: begin
                gen_stage = '0;
                gen_k     = '0;
                issue_nxt = i_start;
            end
            ISSUE: issue_nxt = (k_q != K_LAST);
            DRAIN: begin
                gen_stage = o_stage + SW'(1);
                gen_k     = '0;
                issue_nxt = (drain_cnt == '0) && (o_stage != S_LAST);
            end
            default: issue_nxt = 1'b0;
        endcase
    end

    fft_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
        .stage  (gen_stage),
        .k      (gen_k),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            k_q         <= '0;
            drain_cnt   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_stage     <= '0;
            o_rd_en     <= 1'b0;
            o_rd_addr_a <= '0;
            o_rd_addr_b <= '0;
            o_tw_idx    <= '0;
        end else begin
            o_done  <= 1'b0;
            o_rd_en <= issue_nxt;
            if (issue_nxt) begin
                o_rd_addr_a <= gen_a;
                o_rd_addr_b <= gen_b;
                o_tw_idx    <= gen_tw;
            end
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state   <= ISSUE;
                        k_q     <= '0;
                        o_stage <= gen_stage;
                        o_busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (k_q == K_LAST) begin
                        state     <= DRAIN;
                        drain_cnt <= D_LOAD;
                    end else begin
                        k_q <= gen_k;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        if (o_stage == S_LAST) begin
                            state   <= DONE;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            o_stage <= '0;
                        end else begin
                            state   <= ISSUE;
                            k_q     <= '0;
                            o_stage <= gen_stage;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic  wr_en_pipe [PIPE_LAT];
    addr_t wr_a_pipe  [PIPE_LAT];
    addr_t wr_b_pipe  [PIPE_LAT];

    // Write-back strobe and addresses trail the read issue by exactly PIPE_LAT cycles.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                wr_en_pipe[i] <= 1'b0;
                wr_a_pipe[i]  <= '0;
                wr_b_pipe[i]  <= '0;
            end
        end else begin
            wr_en_pipe[0] <= o_rd_en;
            wr_a_pipe[0]  <= o_rd_addr_a;
            wr_b_pipe[0]  <= o_rd_addr_b;
            for (int i = 1; i < PIPE_LAT; i++) begin
                wr_en_pipe[i] <= wr_en_pipe[i-1];
                wr_a_pipe[i]  <= wr_a_pipe[i-1];
                wr_b_pipe[i]  <= wr_b_pipe[i-1];
            end
        end
    end

    assign o_wr_en     = wr_en_pipe[PIPE_LAT-1];
    assign o_wr_addr_a = wr_a_pipe[PIPE_LAT-1];
    assign o_wr_addr_b = wr_b_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Scoreboard bench: four scheduler configurations, expected read/write/done events queued at stimulus time.
module tb_fft_stage_scheduler;

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int st;
    } ev_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ev_t  rdq [4][$];
    ev_t  wrq [4][$];
    ev_t  hvq [4][$];
    int   dnq [4][$];
    bit   busy_map [4][2048];
    int   cover_mask = 0;
    int   cover_cnt  = 0;

    logic rst0, rst_o, start0, start_o;

    logic       b0, d0, re0, we0;
    logic [3:0] ra0, rb0, wa0, wb0;
    logic [2:0] tw0, st0;
    logic       b1, d1, re1, we1;
    logic [3:0] ra1, rb1, wa1, wb1;
    logic [2:0] tw1, st1;
    logic       b2, d2, re2, we2;
    logic [3:0] ra2, rb2, wa2, wb2;
    logic [2:0] tw2, st2;
    logic       b3, d3, re3, we3;
    logic [1:0] ra3, rb3, wa3, wb3;
    logic [0:0] tw3;
    logic [1:0] st3;

    fft_stage_scheduler #(.N_LOG2(4), .PIPE_LAT(2)) u0 (
        .i_clk(clk), .i_reset(rst0), .i_start(start0), .o_busy(b0), .o_done(d0),
        .o_rd_en(re0), .o_rd_addr_a(ra0), .o_rd_addr_b(rb0), .o_tw_idx(tw0), .o_stage(st0),
        .o_wr_en(we0), .o_wr_addr_a(wa0), .o_wr_addr_b(wb0));

    fft_stage_scheduler #(.N_LOG2(4), .PIPE_LAT(1)) u1 (
        .i_clk(clk), .i_reset(rst_o), .i_start(start_o), .o_busy(b1), .o_done(d1),
        .o_rd_en(re1), .o_rd_addr_a(ra1), .o_rd_addr_b(rb1), .o_tw_idx(tw1), .o_stage(st1),
        .o_wr_en(we1), .o_wr_addr_a(wa1), .o_wr_addr_b(wb1));

    fft_stage_scheduler #(.N_LOG2(4), .PIPE_LAT(4)) u2 (
        .i_clk(clk), .i_reset(rst_o), .i_start(start_o), .o_busy(b2), .o_done(d2),
        .o_rd_en(re2), .o_rd_addr_a(ra2), .o_rd_addr_b(rb2), .o_tw_idx(tw2), .o_stage(st2),
        .o_wr_en(we2), .o_wr_addr_a(wa2), .o_wr_addr_b(wb2));

    fft_stage_scheduler #(.N_LOG2(2), .PIPE_LAT(2)) u3 (
        .i_clk(clk), .i_reset(rst_o), .i_start(start_o), .o_busy(b3), .o_done(d3),
        .o_rd_en(re3), .o_rd_addr_a(ra3), .o_rd_addr_b(rb3), .o_tw_idx(tw3), .o_stage(st3),
        .o_wr_en(we3), .o_wr_addr_a(wa3), .o_wr_addr_b(wb3));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst=%0d cycle=%0d actual=%0d required=%0d", name, id, cyc, act, exp);
        end
    endtask

    task automatic chk_unexp(input string name, input int id);
        checks++;
        errors++;
        $display("FAIL %s inst=%0d cycle=%0d actual=event required=none", name, id, cyc);
    endtask

    // Independent reference: A = (k / h) * 2h + k % h, twiddle step N/2 / h.
    function automatic ev_t mk(input int c, input int nl, input int s, input int k);
        ev_t e;
        int  h;
        h    = 1 << s;
        e.cyc = c;
        e.a   = (k / h) * 2 * h + (k % h);
        e.b   = e.a + h;
        e.tw  = (k % h) * ((1 << (nl - 1)) / h);
        e.st  = s;
        return e;
    endfunction

    task automatic push_run(input int id, input int nl, input int pl, input int t0);
        ev_t e;
        int  len;
        len = (1 << (nl - 1)) + pl;
        for (int s = 0; s < nl; s++) begin
            for (int k = 0; k < (1 << (nl - 1)); k++) begin
                e = mk(t0 + 1 + s * len + k, nl, s, k);
                rdq[id].push_back(e);
                e.cyc = e.cyc + pl;
                wrq[id].push_back(e);
            end
        end
        dnq[id].push_back(t0 + nl * len + 1);
        for (int c = t0 + 1; c <= t0 + nl * len; c++)
            if (c < 2048) busy_map[id][c] = 1'b1;
    endtask

    task automatic hv(input int id, input int c, input int a, input int b, input int tw, input int st);
        ev_t e;
        e.cyc = c; e.a = a; e.b = b; e.tw = tw; e.st = st;
        hvq[id].push_back(e);
    endtask

    task automatic mon(input int id, input logic rd, input int ra, input int rb, input int tw,
                       input int st, input logic wr, input int wa, input int wb,
                       input logic dn, input logic bz);
        ev_t e;
        int  dc;
        if (rd) begin
            if (rdq[id].size() == 0) chk_unexp("rd_unexpected", id);
            else begin
                e = rdq[id].pop_front();
                chk("rd_cycle", id, cyc, e.cyc);
                chk("rd_addr_a", id, ra, e.a);
                chk("rd_addr_b", id, rb, e.b);
                chk("tw_idx", id, tw, e.tw);
                chk("stage", id, st, e.st);
            end
            if (hvq[id].size() > 0 && hvq[id][0].cyc == cyc) begin
                e = hvq[id].pop_front();
                chk("hand_addr_a", id, ra, e.a);
                chk("hand_addr_b", id, rb, e.b);
                chk("hand_tw", id, tw, e.tw);
                chk("hand_stage", id, st, e.st);
            end
        end
        if (wr) begin
            if (wrq[id].size() == 0) chk_unexp("wr_unexpected", id);
            else begin
                e = wrq[id].pop_front();
                chk("wr_cycle", id, cyc, e.cyc);
                chk("wr_addr_a", id, wa, e.a);
                chk("wr_addr_b", id, wb, e.b);
            end
            if (id == 0) begin
                cover_mask = cover_mask | (1 << wa) | (1 << wb);
                cover_cnt++;
                if (cover_cnt == 8) begin
                    chk("stage_cover", 0, cover_mask, 'hFFFF);
                    cover_mask = 0;
                    cover_cnt  = 0;
                end
            end
        end
        if (dn) begin
            if (dnq[id].size() == 0) chk_unexp("done_unexpected", id);
            else begin
                dc = dnq[id].pop_front();
                chk("done_cycle", id, cyc, dc);
            end
        end
        if (cyc < 2048) chk("busy", id, int'(bz), int'(busy_map[id][cyc]));
    endtask

    always @(negedge clk) begin
        mon(0, re0, ra0, rb0, tw0, st0, we0, wa0, wb0, d0, b0);
        mon(1, re1, ra1, rb1, tw1, st1, we1, wa1, wb1, d1, b1);
        mon(2, re2, ra2, rb2, tw2, st2, we2, wa2, wb2, d2, b2);
        mon(3, re3, ra3, rb3, tw3, st3, we3, wa3, wb3, d3, b3);
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk_u0_zero(input string tag);
        chk({tag, "_busy"},  0, b0,  0);
        chk({tag, "_done"},  0, d0,  0);
        chk({tag, "_rd_en"}, 0, re0, 0);
        chk({tag, "_wr_en"}, 0, we0, 0);
        chk({tag, "_rd_a"},  0, ra0, 0);
        chk({tag, "_rd_b"},  0, rb0, 0);
        chk({tag, "_tw"},    0, tw0, 0);
        chk({tag, "_stage"}, 0, st0, 0);
        chk({tag, "_wr_a"},  0, wa0, 0);
        chk({tag, "_wr_b"},  0, wb0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ta, tbb, tc, td;
        rst0 = 1'b0; rst_o = 1'b0; start0 = 1'b0; start_o = 1'b0;
        repeat (3) @(negedge clk);
        chk_u0_zero("reset");
        chk("reset_rd_en", 3, re3, 0);
        chk("reset_wr_en", 3, we3, 0);
        rst0 = 1'b1; rst_o = 1'b1;

        // Run A: all four configurations together, plus a stray start on u0 mid-run.
        @(negedge clk);
        ta = cyc;
        push_run(0, 4, 2, ta);
        push_run(1, 4, 1, ta);
        push_run(2, 4, 4, ta);
        push_run(3, 2, 2, ta);
        hv(0, ta + 2,  2, 3,  0, 0);
        hv(0, ta + 14, 5, 7,  4, 1);
        hv(0, ta + 36, 5, 13, 5, 3);
        hv(3, ta + 1, 0, 1, 0, 0);
        hv(3, ta + 2, 2, 3, 0, 0);
        hv(3, ta + 5, 0, 2, 0, 1);
        hv(3, ta + 6, 1, 3, 1, 1);
        start0 = 1'b1; start_o = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start_o = 1'b0;
        wait_until(ta + 15);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;

        // Run B: start held high, second transform begins the cycle after DONE.
        wait_until(ta + 50);
        tbb = cyc;
        push_run(0, 4, 2, tbb);
        push_run(0, 4, 2, tbb + 42);
        start0 = 1'b1;
        wait_until(tbb + 43);
        start0 = 1'b0;

        // Run C: asynchronous reset during stage 1 aborts the transform.
        wait_until(tbb + 90);
        tc = cyc;
        push_run(0, 4, 2, tc);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_until(tc + 20);
        #2;
        rst0 = 1'b0;
        rdq[0].delete();
        wrq[0].delete();
        dnq[0].delete();
        for (int c = tc + 21; c < 2048; c++) busy_map[0][c] = 1'b0;
        cover_mask = 0;
        cover_cnt  = 0;
        #1;
        chk_u0_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst0 = 1'b1;

        // Run D: clean transform after the abort.
        wait_until(tc + 85);
        td = cyc;
        push_run(0, 4, 2, td);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_until(td + 50);
        chk("idle_stage", 0, st0, 0);

        for (int i = 0; i < 4; i++) begin
            chk("rd_left", i, rdq[i].size(), 0);
            chk("wr_left", i, wrq[i].size(), 0);
            chk("done_left", i, dnq[i].size(), 0);
            chk("hand_left", i, hvq[i].size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
